hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Parametrised hazard controller for the 5-stage RV32I pipeline. It handles E-stage operand forwarding from M and W, load-use stalls, taken-branch flushes and multi-cycle MUL/DIV occupancy of E. It also keeps saturating performance counters for stall and flush cycles. It sits beside the pipeline registers and drives their enable and clear inputs.

Parameters:
REG_AW, 5, register address width; register 0 is hardwired zero
MULDIV_LAT, 4, cycles a MUL/DIV instruction occupies E (legal range 1..255)
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset
Rs1_D  in  REG_AW  decode-stage source 1
Rs2_D  in  REG_AW  decode-stage source 2
Rs1_E  in  REG_AW  execute-stage source 1
Rs2_E  in  REG_AW  execute-stage source 2
RD_E  in  REG_AW  execute-stage destination
RD_M  in  REG_AW  memory-stage destination
RD_W  in  REG_AW  writeback-stage destination
LoadE  in  1  the instruction in E is a load
RegWriteM  in  1  the instruction in M writes the register file
RegWriteW  in  1  the instruction in W writes the register file
PCSrcE  in  1  branch/jump taken in E
MulDivStartE  in  1  a valid MUL/DIV instruction is in E
ForwardAE  out  2  00 = register file, 10 = M, 01 = W
ForwardBE  out  2  same encoding, for operand B
StallF  out  1  hold the PC
StallD  out  1  hold the IF/ID register
StallE  out  1  hold the ID/EX register
FlushD  out  1  clear the IF/ID register
FlushE  out  1  clear the ID/EX register
FlushM  out  1  insert a bubble into EX/MEM
MulDivBusy  out  1  the MUL/DIV unit occupies E
stall_cnt  out  CNT_W  cycles with StallF=1
flush_cnt  out  CNT_W  cycles with FlushD=1 caused by a branch

Behaviour:
- Reset is rst, synchronous, active-high.
  - While rst=1, every combinational output is 0.
  - At the clock edge with rst=1: FSM goes to IDLE, the cycle counter to 0, and stall_cnt and flush_cnt to 0.
  - Reset during BUSY aborts the operation; the cycle after reset shows MulDivBusy=0.
- Forwarding (combinational, zero latency), shown for A; B is identical using Rs2_E:
  - Select M (10) if RegWriteM and RD_M!=0 and RD_M==Rs1_E.
  - Else select W (01) if RegWriteW and RD_W!=0 and RD_W==Rs1_E.
  - Else 00. M has priority over W.
- Load-use detect: lw = LoadE and RD_E!=0 and (RD_E==Rs1_D or RD_E==Rs2_D).
- MUL/DIV FSM:
  - IDLE: when MulDivStartE=1, go to BUSY and load the counter with MULDIV_LAT-1.
    - If MULDIV_LAT=1, stay in IDLE instead (single stall cycle).
  - BUSY: decrement the counter each cycle; when the counter is 0, return to IDLE.
  - MulDivBusy = (state==BUSY) or (state==IDLE and MulDivStartE).
  - Total stall length is exactly MULDIV_LAT cycles per MUL/DIV.
- Output priority, highest first:
  1. MulDivBusy: StallF=StallD=StallE=1, FlushM=1, FlushD=FlushE=0. PCSrcE and lw are ignored (E holds the MUL/DIV, not a branch).
  2. PCSrcE: FlushD=FlushE=1, all stalls 0. A coincident lw is dropped because its consumer is flushed.
  3. lw: StallF=StallD=1, FlushE=1. Exactly one bubble, because RD_E moves on the next cycle.
  4. Otherwise all control outputs are 0.
- Counters (registered, updated at the clock edge):
  - stall_cnt += 1 when StallF=1.
  - flush_cnt += 1 when the PCSrcE rule is active.
  - Both saturate at 2^CNT_W-1 and never wrap.
- In the same cycle, forwarding remains valid regardless of stall/flush state.

Test Plan:
- RD_M=5, RegWriteM=1, RD_W=5, RegWriteW=1, Rs1_E=5, Rs2_E=5 -> ForwardAE=ForwardBE=10. Drop RegWriteM -> both 01. Set RD_M=RD_W=0 -> both 00.
- LoadE=1, RD_E=7, Rs2_D=7 for one cycle -> StallF=StallD=FlushE=1 for exactly 1 cycle; stall_cnt goes 0->1.
- Same load-use with PCSrcE=1 in the same cycle -> FlushD=FlushE=1, StallF=0; flush_cnt=1, stall_cnt=0.
- MULDIV_LAT=4, pulse MulDivStartE -> StallF/StallD/StallE/FlushM high for 4 consecutive cycles, then low. A PCSrcE=1 during cycle 2 has no effect; stall_cnt=4.
- Assert rst in cycle 2 of BUSY -> the cycle after reset shows MulDivBusy=0 and all outputs 0; counters read 0.
- CNT_W=4, hold lw stall for 20 cycles -> stall_cnt saturates at 15 and stays there.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, load-use stall, branch flush and MUL/DIV occupancy control for a 5-stage RV32I pipeline
module hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs1_D,
    input  logic [REG_AW-1:0] Rs2_D,
    input  logic [REG_AW-1:0] Rs1_E,
    input  logic [REG_AW-1:0] Rs2_E,
    input  logic [REG_AW-1:0] RD_E,
    input  logic [REG_AW-1:0] RD_M,
    input  logic [REG_AW-1:0] RD_W,
    input  logic              LoadE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              PCSrcE,
    input  logic              MulDivStartE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              MulDivBusy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t           state_q;
    logic [7:0]       cyc_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             lw, br;
    // Forwarding and stall/flush priority: MUL/DIV occupancy, then branch, then load-use
    always_comb begin
        ForwardAE  = rst ? 2'b00 :
                     (RegWriteM && RD_M != '0 && RD_M == Rs1_E) ? 2'b10 :
                     (RegWriteW && RD_W != '0 && RD_W == Rs1_E) ? 2'b01 : 2'b00;
        ForwardBE  = rst ? 2'b00 :
                     (RegWriteM && RD_M != '0 && RD_M == Rs2_E) ? 2'b10 :
                     (RegWriteW && RD_W != '0 && RD_W == Rs2_E) ? 2'b01 : 2'b00;
        MulDivBusy = !rst && (state_q == BUSY || MulDivStartE);
        br         = !rst && !MulDivBusy && PCSrcE;
        lw         = !rst && !MulDivBusy && !PCSrcE && LoadE && RD_E != '0 &&
                     (RD_E == Rs1_D || RD_E == Rs2_D);
        StallF     = MulDivBusy || lw;
        StallD     = MulDivBusy || lw;
        StallE     = MulDivBusy;
        FlushD     = br;
        FlushE     = br || lw;
        FlushM     = MulDivBusy;
        stall_cnt_d = (StallF && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        flush_cnt_d = (br && flush_cnt_q != '1) ? flush_cnt_q + 1'b1 : flush_cnt_q;
        stall_cnt  = stall_cnt_q;
        flush_cnt  = flush_cnt_q;
    end
    // MUL/DIV occupancy FSM: the start cycle plus MULDIV_LAT-1 BUSY cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cyc_q   <= '0;
        end else if (state_q == IDLE) begin
            if (MulDivStartE && MULDIV_LAT > 1) begin
                state_q <= BUSY;
                cyc_q   <= 8'(MULDIV_LAT - 1);
            end
        end else begin
            cyc_q <= cyc_q - 8'd1;
            if (cyc_q == 8'd1) state_q <= IDLE;
        end
    end
    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of forwarding, stalls, flushes, MUL/DIV occupancy and counter saturation
module tb_hazard_ctrl;
    logic       clk = 0;
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       load_e, rw_m, rw_w, pcsrc_e, md_start;
    logic [1:0] fa, fb;
    logic       stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, md_busy;
    logic [3:0] stall_cnt, flush_cnt;
    int         checks = 0, errors = 0;

    hazard_ctrl #(.REG_AW(5), .MULDIV_LAT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .Rs1_D(rs1_d), .Rs2_D(rs2_d), .Rs1_E(rs1_e), .Rs2_E(rs2_e),
        .RD_E(rd_e), .RD_M(rd_m), .RD_W(rd_w),
        .LoadE(load_e), .RegWriteM(rw_m), .RegWriteW(rw_w),
        .PCSrcE(pcsrc_e), .MulDivStartE(md_start),
        .ForwardAE(fa), .ForwardBE(fb),
        .StallF(stall_f), .StallD(stall_d), .StallE(stall_e),
        .FlushD(flush_d), .FlushE(flush_e), .FlushM(flush_m),
        .MulDivBusy(md_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_in();
        {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
        {load_e, rw_m, rw_w, pcsrc_e, md_start} = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        rst = 0;
    endtask

    // control outputs packed as {StallF,StallD,StallE,FlushD,FlushE,FlushM,MulDivBusy}
    function automatic logic [6:0] ctrl();
        return {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, md_busy};
    endfunction

    initial begin
        clear_in();
        rst = 1;
        tick();
        rd_m = 5; rw_m = 1; rs1_e = 5; rs2_e = 5; load_e = 1; rd_e = 7; rs2_d = 7; md_start = 1; pcsrc_e = 1;
        #1;
        check("rst_fwd", {fa, fb}, 4'b0000);
        check("rst_ctrl", ctrl(), 7'b0);
        check("rst_cnt", {stall_cnt, flush_cnt}, 8'h00);
        tick();
        clear_in();
        rst = 0;
        #1;
        check("idle_ctrl", ctrl(), 7'b0);

        rd_m = 5; rw_m = 1; rd_w = 5; rw_w = 1; rs1_e = 5; rs2_e = 5;
        #1 check("fwd_m", {fa, fb}, 4'b1010);
        rw_m = 0;
        #1 check("fwd_w", {fa, fb}, 4'b0101);
        rd_m = 0; rd_w = 0;
        #1 check("fwd_none", {fa, fb}, 4'b0000);
        rw_m = 1; rs1_e = 0; rs2_e = 0;
        #1 check("fwd_x0", {fa, fb}, 4'b0000);
        rd_m = 5; rd_w = 6; rs1_e = 5; rs2_e = 6;
        #1 check("fwd_split", {fa, fb}, 4'b1001);
        clear_in();

        load_e = 1; rd_e = 7; rs2_d = 7;
        #1 check("lu_ctrl", ctrl(), 7'b1100100);
        rs2_d = 0; rs1_d = 7; rd_e = 0;
        #1 check("lu_rd0", ctrl(), 7'b0);
        rd_e = 7;
        tick();
        clear_in();
        #1;
        check("lu_after", ctrl(), 7'b0);
        check("lu_stall_cnt", stall_cnt, 4'd1);

        do_reset();
        load_e = 1; rd_e = 7; rs2_d = 7; pcsrc_e = 1; rd_m = 3; rw_m = 1; rs1_e = 3;
        #1;
        check("br_ctrl", ctrl(), 7'b0001100);
        check("br_fwd", fa, 2'b10);
        tick();
        clear_in();
        #1 check("br_cnts", {stall_cnt, flush_cnt}, 8'h01);

        do_reset();
        for (int i = 0; i < 5; i++) begin
            md_start = (i == 0);
            pcsrc_e  = (i == 2);
            load_e = (i == 1); rd_e = 4; rs1_d = 4;
            #1 check($sformatf("md_cyc%0d", i), ctrl(), (i < 4) ? 7'b1110011 : 7'b0);
            tick();
        end
        clear_in();
        #1;
        check("md_done", ctrl(), 7'b0);
        check("md_cnts", {stall_cnt, flush_cnt}, 8'h40);

        do_reset();
        md_start = 1;
        tick();
        md_start = 0;
        tick();
        #1 check("md_busy2", md_busy, 1'b1);
        rst = 1;
        #1 check("md_rst_ctrl", ctrl(), 7'b0);
        tick();
        rst = 0;
        #1;
        check("md_post_rst", ctrl(), 7'b0);
        check("md_post_cnt", {stall_cnt, flush_cnt}, 8'h00);
        tick();
        check("md_post_rst2", md_busy, 1'b0);

        load_e = 1; rd_e = 9; rs1_d = 9;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) check("sat_14", stall_cnt, 4'd14);
            if (i == 15) check("sat_15", stall_cnt, 4'd15);
        end
        check("sat_20", stall_cnt, 4'd15);
        check("sat_flush", flush_cnt, 4'd0);
        clear_in();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
